// File: rtl/kbd_pkg.sv
// Shared types and constants for the keyboard scan-code event decoder.
package kbd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE
  } kbd_state_t;

  localparam logic [7:0] KBD_EXT        = 8'hE0;
  localparam logic [7:0] KBD_REL        = 8'hF0;
  localparam logic [7:0] KBD_PAUSE      = 8'hE1;
  localparam logic [7:0] KBD_MAX_NORMAL = 8'h83;
  localparam logic [8:0] KBD_PAUSE_CODE = 9'h1E1;
  // Bytes following E1 that belong to the pause sequence
  localparam logic [2:0] KBD_PAUSE_SKIP = 3'd7;

  // Queue entry: break flag plus 9-bit code (bit8 = extended)
  typedef struct packed {
    logic       brk;
    logic [8:0] code;
  } kbd_ev_t;

  function automatic logic is_normal(input logic [7:0] b);
    return (b != 8'h00) && (b <= KBD_MAX_NORMAL);
  endfunction

endpackage

// File: rtl/kbd_event_fifo.sv
// Event queue: power-of-two depth, head visible combinationally, no
// push->pop bypass, head output holds its last value while empty.
module kbd_event_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic [W-1:0] last_q;
  logic         do_pop, do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a full queue still accepts
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? last_q : mem[rd_ptr[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are only visible through the pointers
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Remember the last shown head so the output holds once the queue drains
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)     last_q <= '0;
    else if (!empty) last_q <= mem[rd_ptr[AW-1:0]];
  end

endmodule

// File: rtl/kbd_event_decoder.sv
// Scan-code parser: turns make/break/extended/pause byte sequences into
// queued key events, with inter-byte timeout and overflow tracking.
module kbd_event_decoder
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       din_new,
  input  logic [7:0] din,
  input  logic       ev_ready,
  input  logic       ovf_clr,
  output logic       ev_valid,
  output logic [8:0] ev_code,
  output logic       ev_break,
  output logic       overflow,
  output logic       seq_error
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  kbd_state_t    state_q, state_d;
  logic [2:0]    skip_q, skip_d;
  logic [CW-1:0] idle_q;
  logic          push, byte_err, tmo;
  kbd_ev_t       push_ev, head;
  logic          full, empty, drop;

  // Next-state and push decode; only din_new cycles advance the parser
  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    push     = 1'b0;
    push_ev  = '0;
    byte_err = 1'b0;
    tmo      = 1'b0;
    if (din_new) begin
      case (state_q)
        ST_IDLE: begin
          if (is_normal(din)) begin
            push    = 1'b1;
            push_ev = '{brk: 1'b0, code: {1'b0, din}};
          end else if (din == KBD_REL) begin
            state_d = ST_BRK;
          end else if (din == KBD_EXT) begin
            state_d = ST_EXT;
          end else if (din == KBD_PAUSE) begin
            state_d = ST_PAUSE;
            skip_d  = KBD_PAUSE_SKIP;
          end
        end
        ST_EXT: begin
          if (is_normal(din)) begin
            push    = 1'b1;
            push_ev = '{brk: 1'b0, code: {1'b1, din}};
            state_d = ST_IDLE;
          end else if (din == KBD_REL) begin
            state_d = ST_EXT_BRK;
          end else if (din != KBD_EXT) begin
            byte_err = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          if (is_normal(din)) begin
            push    = 1'b1;
            push_ev = '{brk: 1'b1, code: {(state_q == ST_EXT_BRK), din}};
          end else begin
            byte_err = 1'b1;
          end
          state_d = ST_IDLE;
        end
        ST_PAUSE: begin
          if (skip_q == 3'd1) begin
            push    = 1'b1;
            push_ev = '{brk: 1'b0, code: KBD_PAUSE_CODE};
            skip_d  = '0;
            state_d = ST_IDLE;
          end else begin
            skip_d = skip_q - 3'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && idle_q == TMO_LAST) begin
      // A byte on the expiry cycle takes the din_new branch, so it wins
      tmo     = 1'b1;
      skip_d  = '0;
      state_d = ST_IDLE;
    end
  end

  // Parser state and pause skip count
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_IDLE;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  // Idle-clock counter, only runs while a sequence is in flight
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)                           idle_q <= '0;
    else if (din_new || state_d == ST_IDLE) idle_q <= '0;
    else                                   idle_q <= idle_q + 1'b1;
  end

  // Registered one-cycle error pulse
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) seq_error <= 1'b0;
    else         seq_error <= byte_err | tmo;
  end

  assign drop = push && full && !(ev_valid && ev_ready);

  // Sticky overflow; a drop in the same cycle beats the clear
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)      overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  kbd_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(kbd_ev_t))
  ) u_fifo (
    .clk    (clk),
    .resetN (resetN),
    .push   (push),
    .pop    (ev_ready),
    .wdata  (push_ev),
    .rdata  (head),
    .full   (full),
    .empty  (empty)
  );

  assign ev_valid = !empty;
  assign ev_code  = head.code;
  assign ev_break = head.brk;

endmodule

// File: tb/tb_kbd_event_decoder.sv
// Self-checking bench: directed sequences plus a randomized byte stream
// compared against a sequence-level reference model.
module tb_kbd_event_decoder;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic       clk = 1'b0;
  logic       resetN;
  logic       din_new, ev_ready, ovf_clr;
  logic [7:0] din;
  logic       ev_valid, ev_break, overflow, seq_error;
  logic [8:0] ev_code;

  kbd_event_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetN(resetN), .din_new(din_new), .din(din),
    .ev_ready(ev_ready), .ovf_clr(ovf_clr), .ev_valid(ev_valid),
    .ev_code(ev_code), .ev_break(ev_break), .overflow(overflow),
    .seq_error(seq_error)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  logic [9:0] got[$];
  int err_seen = 0;

  // Pops and error pulses observed mid-cycle
  always @(negedge clk) begin
    if (resetN) begin
      if (ev_valid && ev_ready) got.push_back({ev_break, ev_code});
      if (seq_error) err_seen++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b, input int g);
    din = b; din_new = 1'b1;
    @(posedge clk); #1;
    din_new = 1'b0;
    cyc(g);
  endtask

  task automatic chk_seg(input string tag, input int base, input logic [9:0] e[$]);
    chk({tag, "_cnt"}, got.size() - base, e.size());
    foreach (e[i]) if (base + i < got.size()) chk(tag, got[base+i], e[i]);
  endtask

  // ---------------- reference model (sequence level) ----------------
  logic [7:0] mq[$];
  logic [9:0] exp_q[$];
  int exp_err;

  function automatic logic norm(input logic [7:0] b);
    return b >= 8'h01 && b <= 8'h83;
  endfunction

  task automatic m_byte(input logic [7:0] b, input int g);
    int e;
    logic [7:0] c;
    logic x;
    if (mq.size() > 0 && g >= TMO) begin exp_err++; mq.delete(); end
    mq.push_back(b);
    if (mq[0] == 8'hE1) begin
      if (mq.size() == 8) begin exp_q.push_back(10'h1E1); mq.delete(); end
      return;
    end
    e = 0;
    while (e < mq.size() && mq[e] == 8'hE0) e++;
    if (e == mq.size()) return;
    x = (e > 0) ? 1'b1 : 1'b0;
    c = mq[e];
    if (norm(c)) begin
      exp_q.push_back({1'b0, x, c}); mq.delete();
    end else if (c == 8'hF0) begin
      if (e + 1 == mq.size()) return;
      if (norm(mq[e+1])) exp_q.push_back({1'b1, x, mq[e+1]});
      else exp_err++;
      mq.delete();
    end else begin
      if (x) exp_err++;
      mq.delete();
    end
  endtask

  function automatic logic [7:0] rnd_byte();
    int r;
    logic [7:0] b;
    r = $urandom_range(0, 19);
    if (r < 9) return 8'($urandom_range(1, 'h83));
    if (r < 12) return 8'hE0;
    if (r < 15) return 8'hF0;
    if (r == 15) return 8'hE1;
    b = 8'($urandom_range('h84, 'hFF));
    if (b == 8'hE0 || b == 8'hE1 || b == 8'hF0) b = 8'h00;
    return b;
  endfunction

  function automatic int rnd_gap();
    int r;
    r = $urandom_range(0, 19);
    if (r < 14) return $urandom_range(0, 3);
    if (r < 16) return TMO - 1;
    if (r < 18) return TMO;
    return TMO + 2;
  endfunction

  int base, ebase, found, g, gprev;
  logic [7:0] b;
  logic [9:0] eq[$];

  initial begin
    resetN = 1'b0; din_new = 1'b0; din = '0; ev_ready = 1'b1; ovf_clr = 1'b0;
    #12;
    chk("rst_valid", ev_valid, 0);
    chk("rst_code", ev_code, 0);
    chk("rst_break", ev_break, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_err", seq_error, 0);
    @(posedge clk); #1; resetN = 1'b1;
    cyc(2);

    // Make then break of a normal key
    base = got.size(); ebase = err_seen;
    send(8'h1C, 0);
    chk("mk_valid", ev_valid, 1);
    chk("mk_code", ev_code, 9'h01C);
    chk("mk_break", ev_break, 0);
    send(8'hF0, 0);
    chk("f0_novalid", ev_valid, 0);
    send(8'h1C, 0);
    chk("brk_valid", ev_valid, 1);
    chk("brk_code", ev_code, 9'h01C);
    chk("brk_break", ev_break, 1);
    cyc(3);
    eq = '{10'h01C, 10'h21C};
    chk_seg("norm_seq", base, eq);

    // Extended make/break
    base = got.size();
    send(8'hE0, 0); send(8'h75, 0); send(8'hE0, 1); send(8'hF0, 2); send(8'h75, 0);
    cyc(3);
    eq = '{10'h175, 10'h375};
    chk_seg("ext_seq", base, eq);
    chk("ext_noerr", err_seen - ebase, 0);

    // Pause sequence
    base = got.size();
    send(8'hE1, 0); send(8'h14, 0); send(8'h77, 1); send(8'hE1, 0);
    send(8'hF0, 0); send(8'h14, 2); send(8'hF0, 0); send(8'h77, 0);
    chk("pause_valid", ev_valid, 1);
    cyc(3);
    eq = '{10'h1E1};
    chk_seg("pause_seq", base, eq);
    chk("pause_noerr", err_seen - ebase, 0);

    // Timeout after F0, then boundary where the byte arrives just in time
    base = got.size();
    send(8'hF0, 0);
    found = 0;
    for (int i = 1; i <= TMO + 5; i++) begin
      @(posedge clk); #1;
      if (seq_error && found == 0) found = i;
    end
    chk("tmo_latency", found, TMO);
    send(8'h1C, 0);
    send(8'hF0, TMO - 1);
    send(8'h1C, 0);
    cyc(3);
    eq = '{10'h01C, 10'h21C};
    chk_seg("tmo_seq", base, eq);
    chk("tmo_errcnt", err_seen - ebase, 1);

    // Overflow with a stalled consumer
    ev_ready = 1'b0;
    base = got.size();
    for (int i = 0; i < 5; i++) send(8'(8'h11 + i), 0);
    chk("ovf_set", overflow, 1);
    chk("ovf_head", ev_code, 9'h011);
    ovf_clr = 1'b1; send(8'h16, 0); ovf_clr = 1'b0;
    chk("ovf_clr_vs_drop", overflow, 1);
    ovf_clr = 1'b1; cyc(1); ovf_clr = 1'b0;
    chk("ovf_cleared", overflow, 0);
    ev_ready = 1'b1; send(8'h17, 0); ev_ready = 1'b0;
    chk("ovf_poppush", overflow, 0);
    chk("ovf_valid", ev_valid, 1);
    ev_ready = 1'b1; cyc(6);
    chk("ovf_empty", ev_valid, 0);
    chk("ovf_hold", ev_code, 9'h017);
    eq = '{10'h011, 10'h012, 10'h013, 10'h014, 10'h017};
    chk_seg("ovf_seq", base, eq);

    // Reset mid-sequence with an event queued
    ev_ready = 1'b0;
    send(8'h1C, 0); send(8'hE0, 0); send(8'hF0, 0);
    #2 resetN = 1'b0;
    #1;
    chk("mrst_valid", ev_valid, 0);
    chk("mrst_code", ev_code, 0);
    @(posedge clk); #1; resetN = 1'b1;
    ebase = err_seen;
    ev_ready = 1'b1;
    base = got.size();
    cyc(2);
    send(8'h75, 0);
    chk("mrst_ev_code", ev_code, 9'h075);
    chk("mrst_ev_break", ev_break, 0);
    cyc(TMO + 3);
    eq = '{10'h075};
    chk_seg("mrst_seq", base, eq);
    chk("mrst_noerr", err_seen - ebase, 0);

    // Randomized stream against the model
    mq.delete(); exp_q.delete(); exp_err = 0;
    base = got.size(); ebase = err_seen; gprev = 0;
    for (int i = 0; i < 400; i++) begin
      b = rnd_byte(); g = rnd_gap();
      m_byte(b, gprev);
      send(b, g);
      gprev = g;
    end
    cyc(TMO + 4);
    if (mq.size() > 0) begin exp_err++; mq.delete(); end
    chk_seg("rnd_ev", base, exp_q);
    chk("rnd_err", err_seen - ebase, exp_err);
    chk("rnd_noovf", overflow, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/kbd_event_decoder.md
KBD_EVENT_DECODER -- requirements
Module: kbd_event_decoder

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the event queue depth; it must be a power of two and at least 2.
REQ-003 Parameter TIMEOUT_CYCLES, default 1_000_000, SHALL set the clocks allowed between bytes of one sequence.
REQ-004 Port list, one per line:
 clk  in  1  system clock
 resetN  in  1  async active-low reset
 din_new  in  1  one-cycle strobe, din valid
 din  in  8  received scan byte
 ev_ready  in  1  consumer accepts head event
 ovf_clr  in  1  clears overflow flag
 ev_valid  out  1  queue non-empty
 ev_code  out  9  head event code, bit8 = extended
 ev_break  out  1  head event is release (1) or press (0)
 overflow  out  1  sticky, event dropped on full queue
 seq_error  out  1  one-cycle pulse, malformed or timed-out sequence

Function
REQ-005 Byte classes SHALL be: normal = 0x01..0x83; EXT = 0xE0; REL = 0xF0; PAUSE = 0xE1; other = everything else.
REQ-006 The parser FSM SHALL have states IDLE, EXT, BRK, EXT_BRK and PAUSE, and SHALL act only on cycles where din_new=1.
REQ-007 In IDLE, the parser SHALL act as follows:
 - normal: push {0,din}, make.
 - REL: go to BRK.
 - EXT: go to EXT.
 - PAUSE: go to PAUSE with skip count = 7.
 - other: ignore, with no error.
REQ-008 In EXT, the parser SHALL act as follows:
 - normal: push {1,din}, make, then IDLE.
 - REL: go to EXT_BRK.
 - EXT: stay in EXT.
 - other: seq_error, then IDLE.
REQ-009 In BRK, the parser SHALL act as follows:
 - normal: push {0,din}, break, then IDLE.
 - anything else: seq_error, then IDLE.
REQ-010 In EXT_BRK, the parser SHALL act as follows:
 - normal: push {1,din}, break, then IDLE.
 - anything else: seq_error, then IDLE.
REQ-011 In PAUSE, each byte SHALL decrement the skip count without content check; at the 7th byte the block SHALL push code 0x1E1, make, and return to IDLE.
REQ-012 The push SHALL occur at the same edge that samples the final byte, so ev_valid rises one clock after din_new when the queue was empty.
REQ-013 In any state other than IDLE, an idle counter SHALL count clocks without din_new.
 - When the count reaches TIMEOUT_CYCLES: go to IDLE, pulse seq_error, discard the partial sequence.
 - Counter resets on every din_new and on entry to IDLE.
REQ-014 If din_new coincides with timeout expiry, the byte SHALL win: it is processed normally and no timeout occurs.
REQ-015 The queue SHALL be FIFO; ev_code and ev_break SHALL be the head entry, valid whenever ev_valid=1; a pop occurs when ev_valid and ev_ready are both 1.
REQ-016 A push to a full queue SHALL behave as follows:
 - With a simultaneous pop: the push succeeds.
 - Otherwise: the event is dropped and overflow is set.
 - Queue contents are unchanged by the drop.
REQ-017 Push and pop on an empty queue SHALL not bypass; the new event appears the next cycle.
REQ-018 ovf_clr SHALL clear overflow; if a drop and ovf_clr coincide, overflow SHALL remain set.
REQ-019 ev_code and ev_break SHALL hold their last values when the queue is empty, and SHALL not be treated as meaningful while ev_valid=0.

Reset
REQ-020 resetN low SHALL asynchronously force the following:
 - FSM to IDLE; skip and timeout counters to 0.
 - Queue empty: ev_valid=0, ev_code=0, ev_break=0.
 - overflow=0, seq_error=0.
REQ-021 Reset asserted mid-sequence or with events queued SHALL discard all state; no event SHALL be emitted after release until a complete new sequence arrives.

Structure
REQ-022 Package kbd_pkg SHALL hold the parser state enum, byte constants (0xE0, 0xF0, 0xE1, max normal 0x83) and the pause event code 0x1E1.
REQ-023 The queue SHALL be a sub-module kbd_event_fifo, parametrised by depth and a 10-bit entry (code plus break flag), with full, empty, push and pop ports.

Verification
REQ-024 Bytes 1C; F0 1C with ev_ready=1 -> events {0x01C, make} then {0x01C, break}, each ev_valid one clock after its final din_new.
REQ-025 Bytes E0 75; E0 F0 75 -> events {0x175, make} then {0x175, break}; no seq_error.
REQ-026 Bytes E1 14 77 E1 F0 14 F0 77 -> exactly one event {0x1E1, make}; no other events.
REQ-027 F0 then no byte for TIMEOUT_CYCLES -> seq_error pulse, return to IDLE; a following 1C gives {0x01C, make}.
REQ-028 With ev_ready=0 and FIFO_DEPTH=4, send 5 make codes -> first 4 queued in order, 5th dropped, overflow=1. Then pop one while pushing one -> accepted, no further drop. Then ovf_clr -> overflow=0.
REQ-029 Assert reset after E0 F0 -> queue empty; a following 75 yields {0x075, make}.
